// File: rtl/mc_pkg.sv
// Shared types and encodings for the multi-cycle MIPS control sequencer.
// The state decode function gives the Moore control word for each state.
package mc_pkg;

   typedef enum logic [3:0] {
      IDLE     = 4'd0,
      FETCH    = 4'd1,
      DECODE   = 4'd2,
      EXEC_R   = 4'd3,
      EXEC_I   = 4'd4,
      MEM_ADDR = 4'd5,
      MEM_RD   = 4'd6,
      MEM_WR   = 4'd7,
      WB_R     = 4'd8,
      WB_I     = 4'd9,
      WB_MEM   = 4'd10,
      BRANCH   = 4'd11,
      JUMP     = 4'd12,
      ERROR    = 4'd13
   } state_e;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic       SRCA_PC     = 1'b0;
   localparam logic       SRCA_RS     = 1'b1;
   localparam logic [1:0] SRCB_RT     = 2'd0;
   localparam logic [1:0] SRCB_FOUR   = 2'd1;
   localparam logic [1:0] SRCB_IMM    = 2'd2;
   localparam logic [1:0] SRCB_IMM_SH = 2'd3;

   localparam logic [1:0] PCSRC_ALU    = 2'd0;
   localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
   localparam logic [1:0] PCSRC_JUMP   = 2'd2;

   typedef struct packed {
      logic       mem_read;
      logic       mem_write;
      logic       iord;
      logic       pc_write;
      logic       pc_write_cond;
      logic [1:0] pc_src;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       reg_write;
      logic       busy;
      logic       error;
   } ctrl_t;

   // FETCH's ir_write / pc_write depend on mem_ready and are added in the top.
   function automatic ctrl_t decode_state(input state_e s);
      ctrl_t c;
      c = '0;
      case (s)
         IDLE: c.busy = 1'b0;
         FETCH: begin
            c.mem_read  = 1'b1;
            c.iord      = 1'b0;
            c.alu_src_a = SRCA_PC;
            c.alu_src_b = SRCB_FOUR;
            c.alu_op    = ALUOP_ADD;
            c.pc_src    = PCSRC_ALU;
            c.busy      = 1'b1;
         end
         DECODE: begin
            c.alu_src_a = SRCA_PC;
            c.alu_src_b = SRCB_IMM_SH;
            c.alu_op    = ALUOP_ADD;
            c.busy      = 1'b1;
         end
         EXEC_R: begin
            c.alu_src_a = SRCA_RS;
            c.alu_src_b = SRCB_RT;
            c.alu_op    = ALUOP_FUNCT;
            c.busy      = 1'b1;
         end
         EXEC_I, MEM_ADDR: begin
            c.alu_src_a = SRCA_RS;
            c.alu_src_b = SRCB_IMM;
            c.alu_op    = ALUOP_ADD;
            c.busy      = 1'b1;
         end
         MEM_RD: begin
            c.mem_read = 1'b1;
            c.iord     = 1'b1;
            c.busy     = 1'b1;
         end
         MEM_WR: begin
            c.mem_write = 1'b1;
            c.iord      = 1'b1;
            c.busy      = 1'b1;
         end
         WB_R: begin
            c.reg_write = 1'b1;
            c.reg_dst   = 1'b1;
            c.busy      = 1'b1;
         end
         WB_I: begin
            c.reg_write = 1'b1;
            c.busy      = 1'b1;
         end
         WB_MEM: begin
            c.reg_write  = 1'b1;
            c.mem_to_reg = 1'b1;
            c.busy       = 1'b1;
         end
         BRANCH: begin
            c.alu_src_a     = SRCA_RS;
            c.alu_src_b     = SRCB_RT;
            c.alu_op        = ALUOP_SUB;
            c.pc_write_cond = 1'b1;
            c.pc_src        = PCSRC_ALUOUT;
            c.busy          = 1'b1;
         end
         JUMP: begin
            c.pc_write = 1'b1;
            c.pc_src   = PCSRC_JUMP;
            c.busy     = 1'b1;
         end
         ERROR: c.error = 1'b1;
         default: c.error = 1'b1;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/mc_mem_timer.sv
// Memory wait-state counter; expired_o flags that the current waiting cycle
// is the MEM_TIMEOUT-th one since the counter was last cleared.
module mc_mem_timer #(
   parameter int unsigned MEM_TIMEOUT = 15
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clear_i,
   input  logic enable_i,
   output logic expired_o
);
   localparam int unsigned W = $clog2(MEM_TIMEOUT + 1);
   localparam logic [W-1:0] LAST = W'(MEM_TIMEOUT - 1);

   logic [W-1:0] cnt_r;
   logic [W-1:0] cnt_next_s;
   logic         expired_r;

   // Next count: a clear on state entry takes priority over a wait cycle
   always_comb begin
      cnt_next_s = cnt_r;
      if (clear_i) begin
         cnt_next_s = {W{1'b0}};
      end else if (enable_i) begin
         cnt_next_s = cnt_r + W'(1);
      end else begin
         cnt_next_s = cnt_r;
      end
   end

   // Counter and registered expiry flag
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         cnt_r     <= {W{1'b0}};
         expired_r <= 1'b0;
      end else begin
         cnt_r     <= cnt_next_s;
         expired_r <= (cnt_next_s == LAST);
      end
   end

   assign expired_o = expired_r;

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: sequences IF/ID/EX/MEM/WB over a shared ALU
// and unified memory port, with memory timeout and retired-instruction count.
module multicycle_ctrl #(
   parameter int unsigned MEM_TIMEOUT = 15,
   parameter int unsigned CNT_W       = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [5:0]       op_i,
   input  logic             zero_i,
   input  logic             mem_ready_i,
   output logic             mem_read_o,
   output logic             mem_write_o,
   output logic             iord_o,
   output logic             ir_write_o,
   output logic             pc_write_o,
   output logic             pc_write_cond_o,
   output logic [1:0]       pc_src_o,
   output logic             alu_src_a_o,
   output logic [1:0]       alu_src_b_o,
   output logic [1:0]       alu_op_o,
   output logic             reg_dst_o,
   output logic             mem_to_reg_o,
   output logic             reg_write_o,
   output logic             busy_o,
   output logic             error_o,
   output logic [CNT_W-1:0] instr_count_o
);
   import mc_pkg::*;

   state_e           state_r;
   state_e           next_s;
   ctrl_t            out_r;
   logic [CNT_W-1:0] count_r;
   logic             retire_s;
   logic             mem_state_s;
   logic             expired_s;
   logic             fetch_done_s;
   logic             unused_zero_s;

   // zero_i is combined with pc_write_cond_o in the datapath, not here
   assign unused_zero_s = zero_i;

   assign mem_state_s  = (state_r == FETCH) || (state_r == MEM_RD) || (state_r == MEM_WR);
   assign fetch_done_s = (state_r == FETCH) && mem_ready_i;

   mc_mem_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .clear_i   (next_s != state_r),
      .enable_i  (mem_state_s && !mem_ready_i),
      .expired_o (expired_s)
   );

   // Next-state logic; ready beats timeout in the memory states
   always_comb begin
      next_s   = state_r;
      retire_s = 1'b0;
      case (state_r)
         IDLE: begin
            if (start_i) next_s = FETCH;
            else         next_s = IDLE;
         end
         FETCH: begin
            if (mem_ready_i)    next_s = DECODE;
            else if (expired_s) next_s = ERROR;
            else                next_s = FETCH;
         end
         DECODE: begin
            case (op_i)
               OP_RTYPE:     next_s = EXEC_R;
               OP_ADDI:      next_s = EXEC_I;
               OP_LW, OP_SW: next_s = MEM_ADDR;
               OP_BEQ:       next_s = BRANCH;
               OP_J:         next_s = JUMP;
               default:      next_s = ERROR;
            endcase
         end
         EXEC_R: next_s = WB_R;
         EXEC_I: next_s = WB_I;
         MEM_ADDR: begin
            if (op_i == OP_LW) next_s = MEM_RD;
            else               next_s = MEM_WR;
         end
         MEM_RD: begin
            if (mem_ready_i)    next_s = WB_MEM;
            else if (expired_s) next_s = ERROR;
            else                next_s = MEM_RD;
         end
         MEM_WR: begin
            if (mem_ready_i)    retire_s = 1'b1;
            else if (expired_s) next_s = ERROR;
            else                next_s = MEM_WR;
         end
         WB_R, WB_I, WB_MEM, BRANCH, JUMP: retire_s = 1'b1;
         ERROR:   next_s = ERROR;
         default: next_s = ERROR;
      endcase
      if (retire_s) begin
         next_s = start_i ? FETCH : IDLE;
      end else begin
         next_s = next_s;
      end
   end

   // State, registered Moore control word and retired-instruction counter
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_r <= IDLE;
         out_r   <= '0;
         count_r <= {CNT_W{1'b0}};
      end else begin
         state_r <= next_s;
         out_r   <= decode_state(next_s);
         if (retire_s) count_r <= count_r + CNT_W'(1);
         else          count_r <= count_r;
      end
   end

   assign mem_read_o      = out_r.mem_read;
   assign mem_write_o     = out_r.mem_write;
   assign iord_o          = out_r.iord;
   assign ir_write_o      = fetch_done_s;
   assign pc_write_o      = out_r.pc_write | fetch_done_s;
   assign pc_write_cond_o = out_r.pc_write_cond;
   assign pc_src_o        = out_r.pc_src;
   assign alu_src_a_o     = out_r.alu_src_a;
   assign alu_src_b_o     = out_r.alu_src_b;
   assign alu_op_o        = out_r.alu_op;
   assign reg_dst_o       = out_r.reg_dst;
   assign mem_to_reg_o    = out_r.mem_to_reg;
   assign reg_write_o     = out_r.reg_write;
   assign busy_o          = out_r.busy;
   assign error_o         = out_r.error;
   assign instr_count_o   = count_r;

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Control sequencer for the multi-cycle version of the MIPS core. It steps one shared ALU, one unified instruction/data memory port and the register file through IF/ID/EX/MEM/WB, so each instruction takes 3-5 cycles plus memory wait states. It replaces the single-cycle opcode decoder and drives the PC, IR, register-file, memory and ALU-source muxes. Memory accesses use a req/ready handshake with a timeout.

Parameters:
MEM_TIMEOUT, 15, max cycles to wait for mem_ready_i before entering ERROR (1..255)
CNT_W, 32, width of retired-instruction counter

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous active-low reset
start_i  in  1  level; leaves IDLE when high, returns to IDLE after current instruction when low
op_i  in  6  opcode, IR[31:26]
zero_i  in  1  ALU zero flag
mem_ready_i  in  1  memory completes the current access this cycle
mem_read_o  out  1  memory read request
mem_write_o  out  1  memory write request
iord_o  out  1  0: address=PC, 1: address=ALUOut
ir_write_o  out  1  load IR from memory data
pc_write_o  out  1  unconditional PC load
pc_write_cond_o  out  1  PC load if zero_i (beq)
pc_src_o  out  2  0: ALU result, 1: ALUOut, 2: jump target
alu_src_a_o  out  1  0: PC, 1: RS
alu_src_b_o  out  2  0: RT, 1: const 4, 2: sign-ext imm, 3: sign-ext imm<<2
alu_op_o  out  2  00 add, 01 sub, 10 funct-decode (same encoding as the ALU_Control input)
reg_dst_o  out  1  0: rt, 1: rd
mem_to_reg_o  out  1  0: ALUOut, 1: MDR
reg_write_o  out  1  register file write enable
busy_o  out  1  high in every state except IDLE and ERROR
error_o  out  1  sticky; high in ERROR
instr_count_o  out  CNT_W  instructions retired since reset

Behaviour:
- State encoding is a 4-bit package enum: IDLE, FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WR, WB_R, WB_I, WB_MEM, BRANCH, JUMP, ERROR.
- Reset (rst_i=0, async): state=IDLE; all outputs 0; instr_count_o=0; timeout counter 0.
- Outputs are a Moore decode of the state, except the gated enables noted below. Unlisted signals are 0.
- IDLE: goes to FETCH the cycle after start_i=1 is sampled.
- FETCH: mem_read_o=1, iord_o=0, alu_src_a_o=0, alu_src_b_o=1, alu_op_o=00, pc_src_o=0.
  - ir_write_o and pc_write_o are asserted only in the cycle where mem_ready_i=1, which is also the exit to DECODE.
  - While mem_ready_i=0, stay in FETCH (wait state).
- DECODE: alu_src_a_o=0, alu_src_b_o=3, alu_op_o=00 (branch target into ALUOut). Next state by op_i:
  - 000000 -> EXEC_R
  - 001000 (addi) -> EXEC_I
  - 100011 or 101011 -> MEM_ADDR
  - 000100 -> BRANCH
  - 000010 -> JUMP
  - any other opcode -> ERROR
- EXEC_R: a=1, b=0, op=10 -> WB_R.
- EXEC_I: a=1, b=2, op=00 -> WB_I.
- MEM_ADDR: a=1, b=2, op=00 -> MEM_RD if op_i=100011, else MEM_WR.
- MEM_RD: mem_read_o=1, iord_o=1; waits for mem_ready_i, then -> WB_MEM.
- MEM_WR: mem_write_o=1, iord_o=1; waits for mem_ready_i, then retires.
- WB_R: reg_write_o=1, reg_dst_o=1, mem_to_reg_o=0; retires.
- WB_I: reg_write_o=1, reg_dst_o=0, mem_to_reg_o=0; retires.
- WB_MEM: reg_write_o=1, reg_dst_o=0, mem_to_reg_o=1; retires.
- BRANCH: a=1, b=0, op=01, pc_write_cond_o=1, pc_src_o=1; retires.
- JUMP: pc_write_o=1, pc_src_o=2; retires.
- Retire: instr_count_o increments by 1 in the exiting cycle; it wraps modulo 2^CNT_W. Next state is FETCH if start_i=1, else IDLE.
- start_i deasserted mid-instruction has no effect until retire.
- Latency with zero wait states: R/addi 4 cycles, lw 5, sw 4, beq 3, j 3 (FETCH to retire inclusive).
- Timeout:
  - The counter clears on entry to FETCH, MEM_RD or MEM_WR.
  - It increments each waiting cycle with mem_ready_i=0.
  - When it reaches MEM_TIMEOUT with mem_ready_i still 0 -> ERROR.
  - If mem_ready_i=1 on the same cycle, ready wins.
- mem_ready_i is ignored outside the three memory states.
- ERROR: all enables 0, error_o=1, busy_o=0. Exited only by reset; start_i is ignored.
- Reset mid-access drops mem_read_o/mem_write_o asynchronously. No register write or PC write occurs in that cycle.

Decomposition:
- Package mc_pkg holds:
  - state enum
  - opcode constants (OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J)
  - ALUOp constants (ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT)
  - ALU-source and pc_src select constants
- One sub-module, mc_mem_timer: wait counter with clear/enable/expired, width $clog2(MEM_TIMEOUT+1).
- The FSM and output decode stay in multicycle_ctrl.

Test Plan:
- Reset with start_i=0, mem_ready_i=1: state IDLE, all outputs 0, busy_o=0, instr_count_o=0; raise start_i -> FETCH next cycle, mem_read_o=1, iord_o=0.
- add (op 000000), mem_ready_i=1 always: exactly 4 busy cycles; reg_write_o=1 with reg_dst_o=1 only in cycle 4; instr_count_o 0->1.
- lw (op 100011) with mem_ready_i held low 3 cycles in MEM_RD: total 8 cycles; mem_read_o=1 and iord_o=1 throughout MEM_RD; WB_MEM has mem_to_reg_o=1.
- beq (op 000100): BRANCH cycle shows pc_write_cond_o=1, pc_src_o=1, alu_op_o=01; 3 cycles total. j (op 000010): pc_write_o=1, pc_src_o=2 in cycle 3.
- Illegal op 111111 -> ERROR after DECODE, error_o=1, count unchanged. Separately, mem_ready_i=0 for 15 cycles in FETCH -> ERROR on the 15th. With MEM_TIMEOUT=15, ready on the 15th cycle -> DECODE.
- start_i dropped during EXEC_R -> instruction completes and retires, then IDLE. Separately, rst_i pulsed low during MEM_WR -> mem_write_o falls immediately, state IDLE, count 0.
